// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
// -----------------------------------------------------------------------------
// Parallel-in / serial-out converter with valid/ready handshakes on both sides.
// A DATA_WIDTH-bit word is accepted into a one-word holding buffer, moved into
// the shift register, and emitted SHIFT_WIDTH bits per output beat
// (BEATS = DATA_WIDTH / SHIFT_WIDTH beats per word). Because the hold buffer
// refills while the shift register drains, words stream back-to-back with no
// idle beat between them, including the BEATS == 1 case.
//
// Parameters
//   DATA_WIDTH  : parallel word width, must be a multiple of SHIFT_WIDTH
//   SHIFT_WIDTH : bits per output beat, >= 1
//   MSB_FIRST   : 0 -> emit the least-significant slice first (shift right)
//                 1 -> emit the most-significant slice first (shift left)
//
// Ports
//   clk        : clock
//   rst        : asynchronous reset, active low
//   flush      : synchronous clear of hold buffer, shifter and beat counter;
//                overrides every other synchronous update, in_valid ignored
//   in_valid   : in_data is valid
//   in_ready   : a word can be accepted this cycle (no in_valid dependency)
//   in_data    : parallel input word
//   out_valid  : out_data carries a beat
//   out_ready  : consumer takes the beat this cycle
//   out_data   : current serial beat (0 while idle)
//   out_last   : current beat is the last beat of its word (0 while idle)
//   busy       : a word is being shifted or waiting in the hold buffer
// -----------------------------------------------------------------------------
module piso_stream #(
  parameter int DATA_WIDTH  = 128,
  parameter int SHIFT_WIDTH = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SHIFT_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   busy
);

  // Guard the divisor so a bad SHIFT_WIDTH reaches the elaboration check
  // below instead of failing on a divide-by-zero first.
  localparam int SW_SAFE  = (SHIFT_WIDTH < 1) ? 1 : SHIFT_WIDTH;
  localparam int BEATS    = DATA_WIDTH / SW_SAFE;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if ((SHIFT_WIDTH < 1) || ((DATA_WIDTH % SW_SAFE) != 0)) begin : g_bad_params
      $fatal(1, "piso_stream: DATA_WIDTH must be a multiple of SHIFT_WIDTH and SHIFT_WIDTH >= 1");
    end
  endgenerate

  // The shifter is either idle or emitting a word; "active" is ST_SHIFT.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                  state_reg,     state_next;
  logic [DATA_WIDTH-1:0]   hold_reg,      hold_next;
  logic                    hold_full_reg, hold_full_next;
  logic [DATA_WIDTH-1:0]   sreg_reg,      sreg_next;
  logic [CNT_W-1:0]        cnt_reg,       cnt_next;

  logic                    active;
  logic                    last_beat;
  logic                    fire_out;
  logic                    end_word;
  logic                    hold_drain;
  logic                    fire_in;
  logic [SHIFT_WIDTH-1:0]  beat_slice;
  logic [DATA_WIDTH-1:0]   sreg_shifted;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign active     = (state_reg == ST_SHIFT);
  assign last_beat  = (cnt_reg == LAST_CNT);
  assign fire_out   = active & out_ready;
  assign end_word   = fire_out & last_beat;

  // The hold buffer empties into the shifter whenever the shifter is idle or
  // is consuming its final beat this cycle; that same cycle the hold buffer
  // may be refilled, which is what removes the bubble between words.
  assign hold_drain = hold_full_reg & (~active | end_word);
  assign in_ready   = ~hold_full_reg | hold_drain;
  assign fire_in    = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Bit-order dependent slice selection and shift direction
  // ---------------------------------------------------------------------------
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign beat_slice   = sreg_reg[DATA_WIDTH-1 -: SHIFT_WIDTH];
      assign sreg_shifted = sreg_reg << SHIFT_WIDTH;
    end else begin : g_lsb_first
      assign beat_slice   = sreg_reg[SHIFT_WIDTH-1:0];
      assign sreg_shifted = sreg_reg >> SHIFT_WIDTH;
    end
  endgenerate

  // The shifter keeps stale residue after the last beat of a word, so the
  // beat is masked with active to present zeros while idle.
  genvar gi;
  generate
    for (gi = 0; gi < SHIFT_WIDTH; gi++) begin : g_out_gate
      assign out_data[gi] = active & beat_slice[gi];
    end
  endgenerate

  assign out_valid = active;
  assign out_last  = active & last_beat;
  assign busy      = active | hold_full_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    sreg_next      = sreg_reg;
    cnt_next       = cnt_reg;

    if (flush) begin
      state_next     = ST_IDLE;
      hold_next      = '0;
      hold_full_next = 1'b0;
      sreg_next      = '0;
      cnt_next       = '0;
    end else begin
      // Shifter side
      case (state_reg)
        ST_IDLE: begin
          if (hold_drain) begin
            sreg_next  = hold_reg;
            cnt_next   = '0;
            state_next = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (hold_drain) begin
            // Last beat consumed and a word is waiting: reload directly.
            sreg_next  = hold_reg;
            cnt_next   = '0;
            state_next = ST_SHIFT;
          end else if (end_word) begin
            cnt_next   = '0;
            state_next = ST_IDLE;
          end else if (fire_out) begin
            sreg_next  = sreg_shifted;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase

      // Hold buffer side: a simultaneous refill wins over the drain so the
      // buffer stays full with the new word.
      if (fire_in) begin
        hold_next      = in_data;
        hold_full_next = 1'b1;
      end else if (hold_drain) begin
        hold_full_next = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      sreg_reg      <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      sreg_reg      <= sreg_next;
      cnt_reg       <= cnt_next;
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// -----------------------------------------------------------------------------
// tb_piso_stream
// -----------------------------------------------------------------------------
// Two instances run side by side from shared clock/reset/flush/out_ready:
//   instance 0: DATA_WIDTH=8,  SHIFT_WIDTH=1, LSB first
//   instance 1: DATA_WIDTH=16, SHIFT_WIDTH=4, MSB first
// Each instance has a two-slot reference model (word being emitted + word
// waiting) whose beats are computed arithmetically from the stored word and
// the beat index, plus a scoreboard that reassembles the emitted beats into
// words and compares them with the words accepted, in order.
// -----------------------------------------------------------------------------
module tb_piso_stream;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic out_ready;

  logic       iv_a, ir_a, ov_a, ol_a, busy_a;
  logic [7:0] id_a;
  logic [0:0] od_a;

  logic        iv_b, ir_b, ov_b, ol_b, busy_b;
  logic [15:0] id_b;
  logic [3:0]  od_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // stimulus
  bit          in_valid [2];
  logic [15:0] in_data  [2];
  logic [15:0] src      [2][64];
  int          s_wr     [2];
  int          s_rd     [2];

  // reference model
  bit          sh_v [2];
  bit          hd_v [2];
  logic [15:0] sh_w [2];
  logic [15:0] hd_w [2];
  int          bi   [2];

  // scoreboard
  logic [15:0] acc   [2][64];
  int          a_wr  [2];
  int          a_rd  [2];
  logic [15:0] asm_w [2];
  logic [15:0] ob_data [2];

  always #5 clk = ~clk;

  piso_stream #(.DATA_WIDTH(8), .SHIFT_WIDTH(1), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .out_last(ol_a), .busy(busy_a)
  );

  piso_stream #(.DATA_WIDTH(16), .SHIFT_WIDTH(4), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .out_last(ol_b), .busy(busy_b)
  );

  function automatic int dw(int i);  return (i == 0) ? 8 : 16; endfunction
  function automatic int sw(int i);  return (i == 0) ? 1 : 4;  endfunction
  function automatic int beats(int i); return dw(i) / sw(i); endfunction
  function automatic bit msb(int i); return (i == 0) ? 1'b0 : 1'b1; endfunction
  function automatic logic [15:0] wmask(int i);
    return (i == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  // Bit position of beat b within its word.
  function automatic int beat_pos(int i, int b);
    return msb(i) ? (dw(i) - (b + 1) * sw(i)) : (b * sw(i));
  endfunction

  function automatic logic [15:0] beat_of(int i, logic [15:0] w, int b);
    logic [15:0] m;
    m = (16'h1 << sw(i)) - 16'h1;
    return (w >> beat_pos(i, b)) & m;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(int i, logic [15:0] w);
    src[i][s_wr[i] % 64] = w & wmask(i);
    s_wr[i]++;
  endtask

  task automatic model_clear(int i);
    sh_v[i]  = 1'b0;
    hd_v[i]  = 1'b0;
    bi[i]    = 0;
    asm_w[i] = '0;
    a_rd[i]  = a_wr[i];
  endtask

  task automatic drive();
    iv_a = in_valid[0];
    id_a = in_data[0][7:0];
    iv_b = in_valid[1];
    id_b = in_data[1];
  endtask

  // mode 0: out_ready=1, in_valid whenever a word is queued
  // mode 1: random out_ready and random in_valid gating
  // mode 2: out_ready pattern 1,0,0,1
  task automatic set_inputs(int mode);
    cyc++;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endcase
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = (s_rd[i] != s_wr[i]) && ((mode != 1) || ($urandom_range(0, 3) != 0));
      in_data[i]  = in_valid[i] ? src[i][s_rd[i] % 64] : 16'($urandom);
    end
    drive();
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic        o_ir, o_ov, o_ol, o_bz;
      logic [15:0] o_d;
      bit          e_last, e_ir;
      o_ir = (i == 0) ? ir_a   : ir_b;
      o_ov = (i == 0) ? ov_a   : ov_b;
      o_ol = (i == 0) ? ol_a   : ol_b;
      o_bz = (i == 0) ? busy_a : busy_b;
      o_d  = (i == 0) ? {15'b0, od_a} : {12'b0, od_b};
      ob_data[i] = o_d;
      e_last = sh_v[i] && (bi[i] == beats(i) - 1);
      e_ir   = !hd_v[i] || !sh_v[i] || (out_ready && e_last);
      chk($sformatf("i%0d_c%0d_in_ready", i, cyc),  {15'b0, o_ir}, {15'b0, e_ir});
      chk($sformatf("i%0d_c%0d_out_valid", i, cyc), {15'b0, o_ov}, {15'b0, sh_v[i]});
      chk($sformatf("i%0d_c%0d_out_last", i, cyc),  {15'b0, o_ol}, {15'b0, e_last});
      chk($sformatf("i%0d_c%0d_busy", i, cyc),      {15'b0, o_bz}, {15'b0, sh_v[i] | hd_v[i]});
      chk($sformatf("i%0d_c%0d_out_data", i, cyc),  o_d,
          sh_v[i] ? beat_of(i, sh_w[i], bi[i]) : 16'h0);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit last, fo, ew, drain, fi;
      if (!rst) begin
        model_clear(i);
      end else if (flush) begin
        model_clear(i);
      end else begin
        last  = sh_v[i] && (bi[i] == beats(i) - 1);
        fo    = sh_v[i] && out_ready;
        ew    = fo && last;
        drain = hd_v[i] && (!sh_v[i] || ew);
        fi    = in_valid[i] && (!hd_v[i] || drain);
        if (fo) begin
          asm_w[i] = asm_w[i] | (ob_data[i] << beat_pos(i, bi[i]));
          if (ew) begin
            if (a_rd[i] == a_wr[i]) begin
              chk($sformatf("i%0d_c%0d_word_unexpected", i, cyc), asm_w[i], 16'hXXXX);
            end else begin
              chk($sformatf("i%0d_c%0d_word", i, cyc), asm_w[i], acc[i][a_rd[i] % 64]);
              a_rd[i]++;
            end
            asm_w[i] = '0;
          end
        end
        if (drain) begin
          sh_w[i] = hd_w[i];
          sh_v[i] = 1'b1;
          bi[i]   = 0;
        end else if (ew) begin
          sh_v[i] = 1'b0;
          bi[i]   = 0;
        end else if (fo) begin
          bi[i]++;
        end
        if (fi) begin
          hd_w[i] = in_data[i] & wmask(i);
          hd_v[i] = 1'b1;
          acc[i][a_wr[i] % 64] = hd_w[i];
          a_wr[i]++;
          s_rd[i]++;
        end else if (drain) begin
          hd_v[i] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic run(int n, int mode);
    for (int k = 0; k < n; k++) begin
      set_inputs(mode);
      step();
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_a_in_ready"},  {15'b0, ir_a},   16'h1);
    chk({tag, "_a_out_valid"}, {15'b0, ov_a},   16'h0);
    chk({tag, "_a_out_data"},  {15'b0, od_a},   16'h0);
    chk({tag, "_a_out_last"},  {15'b0, ol_a},   16'h0);
    chk({tag, "_a_busy"},      {15'b0, busy_a}, 16'h0);
    chk({tag, "_b_in_ready"},  {15'b0, ir_b},   16'h1);
    chk({tag, "_b_out_valid"}, {15'b0, ov_b},   16'h0);
    chk({tag, "_b_out_data"},  {12'b0, od_b},   16'h0);
    chk({tag, "_b_out_last"},  {15'b0, ol_b},   16'h0);
    chk({tag, "_b_busy"},      {15'b0, busy_b}, 16'h0);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      s_wr[i] = 0; s_rd[i] = 0; a_wr[i] = 0; a_rd[i] = 0;
      model_clear(i);
    end
    drive();

    // Reset state
    #1;
    chk_reset_outputs("reset");
    step();
    rst = 1'b1;
    run(2, 0);

    // T1 / T2: single word each, out_ready held high
    push(0, 16'h00A5);
    push(1, 16'h1234);
    run(14, 0);

    // T3: back-to-back words, continuous beats
    push(0, 16'h00F0); push(0, 16'h000F);
    push(1, 16'hABCD); push(1, 16'h5678);
    run(24, 0);

    // T4: backpressure with out_ready pattern 1,0,0,1
    push(0, 16'h00A5); push(1, 16'h1234);
    run(40, 2);

    // T5: flush mid-word with a second word held, in_valid high in the flush cycle
    push(0, 16'h00A5); push(0, 16'h003C);
    push(1, 16'hCAFE); push(1, 16'hBEEF);
    run(5, 0);
    flush = 1'b1;
    set_inputs(0);
    in_valid[0] = 1'b1; in_data[0] = 16'h0077;
    in_valid[1] = 1'b1; in_data[1] = 16'h7777;
    drive();
    step();
    flush = 1'b0;
    push(0, 16'h0099); push(1, 16'h9999);
    run(14, 0);

    // T6: asynchronous reset mid-word, away from a clock edge
    push(0, 16'h00C3); push(1, 16'h1357);
    run(4, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    for (int i = 0; i < 2; i++) model_clear(i);
    set_inputs(0);
    step();
    rst = 1'b1;
    run(3, 0);

    // Randomised traffic with occasional flushes
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) begin
        push(0, 16'($urandom));
        push(1, 16'($urandom));
      end
      run(90, 1);
      flush = 1'b1;
      set_inputs(1);
      step();
      flush = 1'b0;
    end

    // Drain anything still queued
    run(60, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
